uart_mmio: RTL and testbench

Memory-mapped front end for the `Uart` serializer. It sits between the pipeline's data-memory bus and the UART core. CPU stores are queued into a TX FIFO and fed one byte at a time through the core's `write_enable`/`busy` handshake. Bytes received by the core are captured into an RX FIFO for CPU loads. A status register and a software-programmable baud divisor are also provided.

---
 rtl/uart_mmio_pkg.sv | 27 ++
 rtl/uart_mmio_sync_fifo.sv | 59 +++++
 rtl/uart_mmio.sv | 187 ++++++++++++++++++
 tb/tb_uart_mmio.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map, status bit positions and TX FSM states for uart_mmio
package uart_mmio_pkg;

  // Register byte offsets; only bits [3:2] take part in decode.
  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_BAUD   = 4'hC;

  // STATUS register bit positions.
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_AVAIL = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_TX_IDLE  = 6;

  // TX feed state machine.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// rtl/uart_mmio_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and show-ahead head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Equal pointers mean empty; same index with differing wrap bits means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full/empty come from the pre-edge pointers, so a push into a full FIFO is
  // refused even when a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; natural wrap of the extra MSB distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped TX/RX FIFO front end for the Uart serializer core
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] BAUD_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        uart_write_enable,
  output logic [7:0]  uart_data,
  output logic [15:0] uart_baud_max,
  input  logic        uart_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_out_valid
);

  // Bus decode on the word index.
  logic [1:0] sel;
  logic       wr_tx, wr_status, wr_baud;
  logic       rd_rx, rd_status, rd_baud;

  assign sel       = addr[3:2];
  assign wr_tx     = we && (sel == ADDR_TXDATA[3:2]);
  assign wr_status = we && (sel == ADDR_STATUS[3:2]);
  assign wr_baud   = we && (sel == ADDR_BAUD[3:2]);
  assign rd_rx     = re && (sel == ADDR_RXDATA[3:2]);
  assign rd_status = re && (sel == ADDR_STATUS[3:2]);
  assign rd_baud   = re && (sel == ADDR_BAUD[3:2]);

  // Byte-offset bits and upper write-data bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  // Registered state.
  tx_state_t   state_q, state_d;
  logic [7:0]  uart_data_q, uart_data_d;
  logic [15:0] baud_q, baud_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        out_valid_q;
  logic        rx_push_q, rx_push_d;
  logic [7:0]  rx_byte_q;

  // FIFO interfaces.
  logic       tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_q),
    .pop   (rx_pop),
    .din   (rx_byte_q),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // The strobe is a pure function of the state so it lasts exactly one LOAD cycle.
  assign uart_write_enable = (state_q == LOAD);
  assign uart_data         = uart_data_q;
  assign uart_baud_max     = baud_q;
  assign rdata             = rdata_q;
  assign rvalid            = rvalid_q;

  // STATUS view, built from pre-edge state so same-cycle writes are not reflected.
  logic [31:0] status;
  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_AVAIL] = !rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_OVR]   = rx_ovr_q;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_TX_IDLE]  = tx_empty && (state_q == IDLE);
  end

  // TX feed: pop a byte, strobe it into the core, then track busy rise and fall.
  always_comb begin
    state_d     = state_q;
    uart_data_d = uart_data_q;
    tx_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          uart_data_d = tx_dout;
          state_d     = LOAD;
        end
      end
      LOAD:      state_d = WAIT_ACK;
      WAIT_ACK:  if (uart_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!uart_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Read path: one-cycle registered response; an RXDATA read pops on the same edge.
  always_comb begin
    rdata_d  = '0;
    rvalid_d = re;
    rx_pop   = 1'b0;
    if (rd_rx && !rx_empty) begin
      rdata_d = {24'b0, rx_dout};
      rx_pop  = 1'b1;
    end else if (rd_status) begin
      rdata_d = status;
    end else if (rd_baud) begin
      rdata_d = {16'b0, baud_q};
    end
  end

  // RX capture: a rising edge of the core's valid launches one registered push.
  always_comb begin
    rx_push_d = uart_out_valid && !out_valid_q;
  end

  // Sticky error flags (setting beats a same-cycle clear) and the baud divisor.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovr_d = rx_ovr_q;
    baud_d   = baud_q;
    if (wr_status && wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (wr_status && wdata[ST_RX_OVR]) rx_ovr_d = 1'b0;
    if (wr_tx && tx_full)              tx_ovf_d = 1'b1;
    if (rx_push_q && rx_full)          rx_ovr_d = 1'b1;
    if (wr_baud && (wdata[15:0] != 16'd0)) baud_d = wdata[15:0];
  end

  // State registers; reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      uart_data_q <= 8'd0;
      baud_q      <= BAUD_DEFAULT;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      rx_push_q   <= 1'b0;
      rx_byte_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      uart_data_q <= uart_data_d;
      baud_q      <= baud_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovr_q    <= rx_ovr_d;
      out_valid_q <= uart_out_valid;
      rx_push_q   <= rx_push_d;
      rx_byte_q   <= uart_rx_data;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - directed/randomized self-checking bench for uart_mmio
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;
  logic        uart_write_enable;
  logic [7:0]  uart_data;
  logic [15:0] uart_baud_max;
  logic        uart_busy = 1'b0;
  logic [7:0]  uart_rx_data;
  logic        uart_out_valid;

  always #5 clk = ~clk;

  uart_mmio #(
    .TX_DEPTH     (16),
    .RX_DEPTH     (16),
    .BAUD_DEFAULT (16'd434)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .we                (we),
    .wdata             (wdata),
    .re                (re),
    .rdata             (rdata),
    .rvalid            (rvalid),
    .uart_write_enable (uart_write_enable),
    .uart_data         (uart_data),
    .uart_baud_max     (uart_baud_max),
    .uart_busy         (uart_busy),
    .uart_rx_data      (uart_rx_data),
    .uart_out_valid    (uart_out_valid)
  );

  int ncmp  = 0;
  int nfail = 0;

  // Behavioural UART core: each write_enable starts a 20-cycle busy frame.
  int         pulses    = 0;
  int         busy_viol = 0;
  int         busy_cnt  = 0;
  bit         busy_force = 1'b0;
  logic [7:0] sent_q[$];

  always @(negedge clk) begin
    if (uart_write_enable) begin
      if (uart_busy) busy_viol++;
      sent_q.push_back(uart_data);
      pulses++;
      busy_cnt = 20;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    uart_busy = busy_force || (busy_cnt > 0);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    re   = 1'b1;
    @(posedge clk);
    #1;
    re = 1'b0;
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    d = rdata;
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int k = 0;
    while (pulses < target && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, {31'b0, pulses >= target}, 32'd1);
  endtask

  task automatic wait_not_busy(input string tag, input int budget);
    int k = 0;
    while (uart_busy && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, {31'b0, uart_busy}, 32'd0);
  endtask

  task automatic inject(input logic [7:0] b, input int hi);
    uart_rx_data   = b;
    uart_out_valid = 1'b1;
    step(hi);
    uart_out_valid = 1'b0;
    step(2);
  endtask

  // Expected STATUS from the abstract queue occupancy and flag state.
  function automatic logic [31:0] exp_status(input int txc, input bit fsm_idle, input int rxc,
                                             input bit rovr, input bit tovf);
    logic [31:0] s;
    s    = '0;
    s[0] = (txc == 16);
    s[1] = (txc == 0);
    s[2] = (rxc > 0);
    s[3] = (rxc == 16);
    s[4] = rovr;
    s[5] = tovf;
    s[6] = (txc == 0) && fsm_idle;
    return s;
  endfunction

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic [15:0] bv;
    logic [7:0]  txm[$];
    logic [7:0]  rxm[$];
    bit          rovr;
    int          saved;

    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = '0;
    uart_rx_data = 8'h00; uart_out_valid = 1'b0;
    step(3);
    rst = 1'b0;

    chk("rst_we", {31'b0, uart_write_enable}, 32'd0);
    chk("rst_data", {24'b0, uart_data}, 32'd0);
    chk("rst_baud", {16'b0, uart_baud_max}, 32'd434);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rd(4'h8, d); chk("rst_status", d, 32'h42);
    rd(4'hC, d); chk("rst_baud_rd", d, 32'd434);
    rd(4'h0, d); chk("txdata_rd", d, 32'd0);
    rd(4'h4, d); chk("rx_empty_rd", d, 32'd0);

    // Single byte: strobe two cycles after the write, held data, idle afterwards.
    addr = 4'h0; wdata = 32'h41; we = 1'b1;
    step(1);
    we = 1'b0;
    chk("tx_lat1", {31'b0, uart_write_enable}, 32'd0);
    step(1);
    chk("tx_lat2", {31'b0, uart_write_enable}, 32'd1);
    chk("tx_data", {24'b0, uart_data}, 32'h41);
    step(1);
    chk("tx_one_cycle", {31'b0, uart_write_enable}, 32'd0);
    wait_not_busy("tx1_done", 60);
    rd(4'h8, d); chk("tx1_idle", d, exp_status(0, 1, 0, 0, 0));
    chk("tx1_pulses", pulses, 32'd1);
    chk("tx1_sent", {24'b0, sent_q[0]}, 32'h41);
    chk("tx1_hold", {24'b0, uart_data}, 32'h41);

    // Baud divisor: zero ignored, random nonzero value taken.
    wr(4'hC, 32'd0);
    chk("baud_zero", {16'b0, uart_baud_max}, 32'd434);
    bv = 16'($urandom_range(1, 65535));
    wr(4'hC, {16'hFFFF, bv});
    chk("baud_set", {16'b0, uart_baud_max}, {16'b0, bv});
    rd(4'hC, d); chk("baud_rd", d, {16'b0, bv});

    // TX overflow: FSM parked in WAIT_DONE, then 17 back-to-back writes.
    wr(4'h0, 32'($urandom_range(0, 255)));
    wait_pulses("ovf_first", 2, 10);
    busy_force = 1'b1;
    txm.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (txm.size() < 16) txm.push_back(b);
      addr = 4'h0; wdata = {24'b0, b}; we = 1'b1;
      step(1);
    end
    we = 1'b0;
    rd(4'h8, d); chk("ovf_status", d, exp_status(16, 0, 0, 0, 1));
    chk("ovf_no_pulse", pulses, 32'd2);
    wr(4'h8, 32'h20);
    rd(4'h8, d); chk("ovf_clear", d, exp_status(16, 0, 0, 0, 0));
    busy_force = 1'b0;
    wait_pulses("ovf_drain", 18, 1000);
    chk("ovf_count", sent_q.size(), 32'd18);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_byte%0d", i), {24'b0, sent_q[i + 2]}, {24'b0, txm[i]});
    end
    chk("busy_viol", busy_viol, 32'd0);
    wait_not_busy("ovf_done", 60);
    rd(4'h8, d); chk("ovf_idle", d, exp_status(0, 1, 0, 0, 0));

    // RX single byte: long valid pulse, rx_avail appears two cycles after the rise.
    uart_rx_data = 8'h5A; uart_out_valid = 1'b1;
    rd(4'h8, d); chk("rx_lat0", d, exp_status(0, 1, 0, 0, 0));
    rd(4'h8, d); chk("rx_lat1", d, exp_status(0, 1, 0, 0, 0));
    rd(4'h8, d); chk("rx_lat2", d, exp_status(0, 1, 1, 0, 0));
    step(47);
    uart_out_valid = 1'b0;
    step(2);
    rd(4'h4, d); chk("rx_byte", d, 32'h5A);
    rd(4'h4, d); chk("rx_second", d, 32'd0);
    rd(4'h8, d); chk("rx_drained", d, exp_status(0, 1, 0, 0, 0));

    // RX overflow: 17 random bytes with no reads.
    rxm.delete();
    rovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (rxm.size() < 16) rxm.push_back(b);
      else rovr = 1'b1;
      inject(b, 3);
    end
    rd(4'h8, d); chk("rx_ovr_status", d, exp_status(0, 1, rxm.size(), rovr, 0));
    for (int i = 0; i < 16; i++) begin
      rd(4'h4, d); chk($sformatf("rx_byte%0d", i), d, {24'b0, rxm[i]});
    end
    rd(4'h4, d); chk("rx_ovr_empty", d, 32'd0);
    rd(4'h8, d); chk("rx_ovr_sticky", d, exp_status(0, 1, 0, 1, 0));
    wr(4'h8, 32'h10);
    rd(4'h8, d); chk("rx_ovr_clear", d, exp_status(0, 1, 0, 0, 0));

    // Reset during WAIT_DONE with three bytes queued.
    saved = pulses;
    wr(4'h0, 32'($urandom_range(0, 255)));
    wait_pulses("rst_first", saved + 1, 10);
    busy_force = 1'b1;
    step(2);
    for (int i = 0; i < 3; i++) wr(4'h0, 32'($urandom_range(0, 255)));
    rst = 1'b1;
    step(1);
    chk("rst_mid_we", {31'b0, uart_write_enable}, 32'd0);
    rst = 1'b0;
    rd(4'h8, d); chk("rst_mid_status", d, exp_status(0, 1, 0, 0, 0));
    chk("rst_mid_baud", {16'b0, uart_baud_max}, 32'd434);
    saved = pulses;
    busy_force = 1'b0;
    step(60);
    chk("rst_no_pulse", pulses, saved);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
